// File: rtl/vga_raster_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_raster_timing
//  Purpose  : Free-running raster timing generator for the camera loopback
//             path. It produces registered, cycle-aligned sync, blank and
//             camera-request outputs, row/col coordinates for the downstream
//             RGB stage, line/frame start markers and a frame counter.
//  Ports    : clk          - pixel clock, sole clock
//             reset_n      - asynchronous active-low reset
//             en           - count enable; 0 holds every register
//             x_count      - horizontal position, 0..H_TOTAL-1
//             y_count      - vertical position, 0..V_TOTAL-1
//             col / row    - x_count-COL_OFS / y_count-ROW_OFS, modulo 2^13
//             hs_n / vs_n  - horizontal / vertical sync, active low
//             blank_n      - 1 during active video
//             orequest     - camera pixel read request
//             sol / sof    - one-cycle start-of-line / start-of-frame pulses
//             frame_count  - completed frames, wraps at 2^16
//  Revision : 1.0 - initial release
// ============================================================================
module vga_raster_timing #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACT    = 160,
  parameter int H_SYNC_S = 2,
  parameter int H_SYNC_E = 97,
  parameter int V_TOTAL  = 525,
  parameter int V_ACT    = 45,
  parameter int V_SYNC_S = 13,
  parameter int V_SYNC_E = 14,
  parameter int COL_OFS  = 164,
  parameter int ROW_OFS  = 47
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [12:0] x_count,
  output logic [12:0] y_count,
  output logic [12:0] col,
  output logic [12:0] row,
  output logic        hs_n,
  output logic        vs_n,
  output logic        blank_n,
  output logic        orequest,
  output logic        sol,
  output logic        sof,
  output logic [15:0] frame_count
);

  localparam logic [12:0] c_H_TOTAL  = 13'(H_TOTAL);
  localparam logic [12:0] c_H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] c_H_ACT    = 13'(H_ACT);
  localparam logic [12:0] c_H_SYNC_S = 13'(H_SYNC_S);
  localparam logic [12:0] c_H_SYNC_E = 13'(H_SYNC_E);
  localparam logic [12:0] c_V_TOTAL  = 13'(V_TOTAL);
  localparam logic [12:0] c_V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] c_V_ACT    = 13'(V_ACT);
  localparam logic [12:0] c_V_SYNC_S = 13'(V_SYNC_S);
  localparam logic [12:0] c_V_SYNC_E = 13'(V_SYNC_E);
  localparam logic [12:0] c_COL_OFS  = 13'(COL_OFS);
  localparam logic [12:0] c_ROW_OFS  = 13'(ROW_OFS);
  localparam logic [12:0] c_COL_RST  = 13'd0 - c_COL_OFS;
  localparam logic [12:0] c_ROW_RST  = 13'd0 - c_ROW_OFS;

  logic [12:0] r_x, r_y, r_col, r_row;
  logic        r_hs_n, r_vs_n, r_blank_n, r_orequest, r_sol, r_sof;
  logic [15:0] r_frame_count;

  logic        w_x_wrap, w_y_wrap;
  logic [12:0] w_x_nxt, w_y_nxt;
  logic        w_hs_n_nxt, w_vs_n_nxt, w_blank_n_nxt, w_orequest_nxt;

  // Next counter position. The decode below works on these values so that
  // the registered outputs line up with the counter they are stored beside.
  always_comb begin
    w_x_wrap = (r_x == c_H_LAST);
    w_y_wrap = (r_y == c_V_LAST);
    w_x_nxt  = w_x_wrap ? 13'd0 : r_x + 13'd1;
    w_y_nxt  = r_y;
    if (w_x_wrap) begin
      w_y_nxt = w_y_wrap ? 13'd0 : r_y + 13'd1;
    end
  end

  always_comb begin
    w_hs_n_nxt     = !((w_x_nxt >= c_H_SYNC_S) && (w_x_nxt <= c_H_SYNC_E));
    w_vs_n_nxt     = !((w_y_nxt >= c_V_SYNC_S) && (w_y_nxt <= c_V_SYNC_E));
    w_blank_n_nxt  = (w_x_nxt >= c_H_ACT) && (w_y_nxt >= c_V_ACT);
    // Request uses strict lower bounds: it starts one pixel and one line
    // after the blanking edge.
    w_orequest_nxt = (w_x_nxt > c_H_ACT) && (w_x_nxt < c_H_TOTAL) &&
                     (w_y_nxt > c_V_ACT) && (w_y_nxt < c_V_TOTAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= 13'd0;
      r_y           <= 13'd0;
      r_col         <= c_COL_RST;
      r_row         <= c_ROW_RST;
      r_hs_n        <= 1'b1;
      r_vs_n        <= 1'b1;
      r_blank_n     <= 1'b0;
      r_orequest    <= 1'b0;
      r_sol         <= 1'b0;
      r_sof         <= 1'b0;
      r_frame_count <= 16'd0;
    end else if (en) begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_col      <= w_x_nxt - c_COL_OFS;
      r_row      <= w_y_nxt - c_ROW_OFS;
      r_hs_n     <= w_hs_n_nxt;
      r_vs_n     <= w_vs_n_nxt;
      r_blank_n  <= w_blank_n_nxt;
      r_orequest <= w_orequest_nxt;
      // Markers fire only on a wrap, never on the first cycle out of reset.
      r_sol      <= w_x_wrap;
      r_sof      <= w_x_wrap && w_y_wrap;
      if (w_x_wrap && w_y_wrap) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign x_count     = r_x;
  assign y_count     = r_y;
  assign col         = r_col;
  assign row         = r_row;
  assign hs_n        = r_hs_n;
  assign vs_n        = r_vs_n;
  assign blank_n     = r_blank_n;
  assign orequest    = r_orequest;
  assign sol         = r_sol;
  assign sof         = r_sof;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_raster_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_raster_timing
//  Purpose  : Self-checking bench for vga_raster_timing. A full-size instance
//             is followed cycle by cycle against a reference model through a
//             scoreboard queue, with a table of hand-derived checkpoints; a
//             reduced-size instance covers whole-frame behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_raster_timing;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        en_s;

  logic [12:0] x_count, y_count, col, row;
  logic        hs_n, vs_n, blank_n, orequest, sol, sof;
  logic [15:0] frame_count;

  logic [12:0] s_x, s_y, s_col, s_row;
  logic        s_hs_n, s_vs_n, s_blank_n, s_orequest, s_sol, s_sof;
  logic [15:0] s_frame_count;

  always #5 clk = ~clk;

  vga_raster_timing u_dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .x_count(x_count), .y_count(y_count), .col(col), .row(row),
    .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n), .orequest(orequest),
    .sol(sol), .sof(sof), .frame_count(frame_count)
  );

  // 16x10 raster, VS on line 1 only.
  vga_raster_timing #(
    .H_TOTAL(16), .H_ACT(4), .H_SYNC_S(1), .H_SYNC_E(2),
    .V_TOTAL(10), .V_ACT(3), .V_SYNC_S(1), .V_SYNC_E(1),
    .COL_OFS(5), .ROW_OFS(4)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .en(en_s),
    .x_count(s_x), .y_count(s_y), .col(s_col), .row(s_row),
    .hs_n(s_hs_n), .vs_n(s_vs_n), .blank_n(s_blank_n), .orequest(s_orequest),
    .sol(s_sol), .sof(s_sof), .frame_count(s_frame_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct packed {
    logic [12:0] x, y, col, row;
    logic        hs_n, vs_n, blank_n, orequest, sol, sof;
    logic [15:0] fc;
  } obs_t;

  obs_t sb_q[$];

  // Reference model state (full-size timing).
  int   mx, my, mfc;
  logic msol, msof;

  function automatic void model_reset();
    mx = 0; my = 0; mfc = 0; msol = 1'b0; msof = 1'b0;
  endfunction

  function automatic void model_step();
    msol = (mx == 799);
    msof = (mx == 799) && (my == 524);
    if (mx == 799) begin
      mx = 0;
      if (my == 524) begin
        my  = 0;
        mfc = (mfc + 1) % 65536;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x        = 13'(mx);
    o.y        = 13'(my);
    o.col      = 13'(mx - 164);
    o.row      = 13'(my - 47);
    o.hs_n     = !(mx >= 2 && mx <= 97);
    o.vs_n     = !(my >= 13 && my <= 14);
    o.blank_n  = (mx >= 160) && (my >= 45);
    o.orequest = (mx > 160) && (mx < 800) && (my > 45) && (my < 525);
    o.sol      = msol;
    o.sof      = msof;
    o.fc       = 16'(mfc);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = x_count; o.y = y_count; o.col = col; o.row = row;
    o.hs_n = hs_n; o.vs_n = vs_n; o.blank_n = blank_n; o.orequest = orequest;
    o.sol = sol; o.sof = sof; o.fc = frame_count;
    return o;
  endfunction

  task automatic sb_check();
    obs_t e, a;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard: queue empty, got x=%0d required an entry", x_count);
      return;
    end
    e = sb_q.pop_front();
    a = dut_obs();
    if (a === e) n_pass++;
    else $display("FAIL scoreboard: got x=%0d y=%0d col=%0d row=%0d hs=%b vs=%b bl=%b rq=%b sol=%b sof=%b fc=%0d expected x=%0d y=%0d col=%0d row=%0d hs=%b vs=%b bl=%b rq=%b sol=%b sof=%b fc=%0d",
                  a.x, a.y, a.col, a.row, a.hs_n, a.vs_n, a.blank_n, a.orequest, a.sol, a.sof, a.fc,
                  e.x, e.y, e.col, e.row, e.hs_n, e.vs_n, e.blank_n, e.orequest, e.sol, e.sof, e.fc);
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the
  // next falling edge.
  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    if (e) model_step();
    sb_q.push_back(model_obs());
    @(negedge clk);
    sb_check();
  endtask

  typedef struct {
    int cycles;
    int x, y, hs, vs, blank, oreq, sol, sof, col, row;
  } vec_t;

  vec_t vecs[9];
  obs_t held;
  int   sof_cnt, vs_cnt;

  initial begin
    //          cyc    x    y  hs vs bl rq sol sof  col   row
    vecs[0] = '{5,     5,   0, 0, 1, 0, 0, 0, 0, 8033, 8145};
    vecs[1] = '{794, 799,   0, 1, 1, 0, 0, 0, 0,  635, 8145};
    vecs[2] = '{1,     0,   1, 1, 1, 0, 0, 1, 0, 8028, 8146};
    vecs[3] = '{1,     1,   1, 1, 1, 0, 0, 0, 0, 8029, 8146};
    vecs[4] = '{9599,  0,  13, 1, 0, 0, 0, 1, 0, 8028, 8158};
    vecs[5] = '{26560, 160, 46, 1, 1, 1, 0, 0, 0, 8188, 8191};
    vecs[6] = '{1,   161,  46, 1, 1, 1, 1, 0, 0, 8189, 8191};
    vecs[7] = '{803, 164,  47, 1, 1, 1, 1, 0, 0,    0,    0};
    vecs[8] = '{136, 300,  47, 1, 1, 1, 1, 0, 0,  136,    0};

    reset_n = 1'b0;
    en      = 1'b0;
    en_s    = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_x", x_count, 0);
    check("rst_col", col, 8028);
    check("rst_row", row, 8145);
    check("rst_hs_vs_bl_rq", {hs_n, vs_n, blank_n, orequest}, 4'b1100);
    check("rst_sol_sof_fc", {sol, sof, frame_count}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      repeat (vecs[i].cycles) tick(1'b1);
      check($sformatf("v%0d.x", i), x_count, vecs[i].x);
      check($sformatf("v%0d.y", i), y_count, vecs[i].y);
      check($sformatf("v%0d.hs_n", i), hs_n, vecs[i].hs);
      check($sformatf("v%0d.vs_n", i), vs_n, vecs[i].vs);
      check($sformatf("v%0d.blank_n", i), blank_n, vecs[i].blank);
      check($sformatf("v%0d.orequest", i), orequest, vecs[i].oreq);
      check($sformatf("v%0d.sol", i), sol, vecs[i].sol);
      check($sformatf("v%0d.sof", i), sof, vecs[i].sof);
      check($sformatf("v%0d.col", i), col, vecs[i].col);
      check($sformatf("v%0d.row", i), row, vecs[i].row);
    end

    // Enable low for 10 clocks at x=300: everything frozen, then resume.
    held = dut_obs();
    repeat (10) tick(1'b0);
    check("hold_frozen", int'(dut_obs() === held), 1);
    check("hold_x", x_count, 300);
    tick(1'b1);
    check("resume_x", x_count, 301);

    // A start-of-line pulse stays high while enable is low.
    repeat (499) tick(1'b1);
    check("sol_at_wrap", sol, 1);
    repeat (3) tick(1'b0);
    check("sol_held", sol, 1);
    tick(1'b1);
    check("sol_released", sol, 0);
    check("sol_rel_x", x_count, 1);

    // Asynchronous reset between edges at (400,48).
    repeat (399) tick(1'b1);
    check("pre_rst_x", x_count, 400);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_x", x_count, 0);
    check("async_rst_y", y_count, 0);
    check("async_rst_col", col, 8028);
    check("async_rst_row", row, 8145);
    check("async_rst_flags", {hs_n, vs_n, blank_n, orequest, sol, sof}, 6'b110000);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_release_x", x_count, 0);
    tick(1'b1);
    check("restart_x", x_count, 1);

    // Whole-frame behaviour on the reduced raster (160 clocks per frame).
    en      = 1'b0;
    en_s    = 1'b1;
    sof_cnt = 0;
    vs_cnt  = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (s_sof) sof_cnt++;
      if (!s_vs_n) vs_cnt++;
    end
    check("small_sof_count", sof_cnt, 1);
    check("small_sof_now", s_sof, 1);
    check("small_xy_zero", {s_x, s_y}, 0);
    check("small_fc1", s_frame_count, 1);
    check("small_vs_low_clocks", vs_cnt, 16);
    repeat (160) @(negedge clk);
    check("small_fc2", s_frame_count, 2);
    en_s = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
